hw_malloc_rsv: RTL and testbench
================================

Name: hw_malloc_rsv

Overview:
- Parametrised successor cell allocator for the GSM switch ingress path.
- Owns its free-address list internally as a FIFO of 2**AWIDTH entries, so the external address FIFO is no longer needed.
- Reserves a packet's full cell budget at header time and returns unused reservation at packet tail.
- Accepts freed cell addresses from GSM egress, and reports occupancy and a low-space watermark.

Parameters:
- MWIDTH, 4, number of output ports = multicast vector width
- LWIDTH, 7, width of packet-length field, in 16-byte cells
- AWIDTH, 7, cell address width; pool = 2**AWIDTH cells
- HM_OFFSET, 0, LSB of multicast vector inside i_ingress_dest_ip
- LOW_WM, 16, o_low_space asserts when free count < LOW_WM

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- clr, in, 1, synchronous clear; restarts the INIT sweep
- i_ingress_pkt_length, in, LWIDTH, cells in packet; valid on header beat
- i_ingress_dest_ip, in, 32, destination field; multicast bits [HM_OFFSET+MWIDTH-1:HM_OFFSET]
- i_ingress_valid, in, 1, cell beat valid
- i_ingress_header, in, 1, first beat of packet (qualified by valid)
- i_ingress_last, in, 1, final beat of packet (qualified by valid; may coincide with header)
- o_ready, out, 1, 0 during INIT; ingress beats ignored while 0
- o_gsm_multicast, out, MWIDTH, multicast vector of current cell
- o_gsm_cell_addr, out, AWIDTH, allocated cell address
- o_gsm_wr_en, out, 1, cell write strobe
- o_pkt_drop, out, 1, one-cycle pulse: header rejected
- o_overrun, out, 1, one-cycle pulse: beat beyond declared length discarded
- i_free_valid, in, 1, cell freed by egress
- i_free_addr, in, AWIDTH, freed address
- o_free_cnt, out, AWIDTH+1, unreserved free cells
- o_low_space, out, 1, o_free_cnt < LOW_WM

Behaviour:
- Reset/clr:
  - all outputs 0; state INIT; FIFO pointers 0; o_free_cnt=0; rsv_left=0; pkt_drop=0.
- INIT:
  - one push per cycle of addresses 0..2**AWIDTH-1, in order.
  - after the last push: state RUN, o_ready=1, o_free_cnt=2**AWIDTH.
  - i_free_valid and ingress are ignored during INIT.
- RUN, header beat:
  - accept iff length != 0, length <= o_free_cnt, and the multicast field != 0.
  - accept: latch multicast_vec; rsv_left = length-1; o_free_cnt -= length; pop one address.
  - reject: pkt_drop=1; o_pkt_drop pulses next cycle; all later beats of the packet are ignored.
- RUN, non-header beat of an accepted packet:
  - if rsv_left > 0: pop, rsv_left -= 1.
  - else: no pop; o_overrun pulses next cycle.
- Last beat, accepted packet: after that beat's pop, remaining rsv_left is returned to o_free_cnt, and rsv_left becomes 0.
- Free: i_free_valid pushes i_free_addr and adds 1 to o_free_cnt.
- Free-count update: same-cycle reservation, tail return and free are summed in a single update: cnt' = cnt - rsv + ret + free.
- FIFO: pop and push in the same cycle are both legal. A pop never underflows, because a reservation always precedes the pop.
- Latency:
  - o_gsm_wr_en, o_gsm_cell_addr and o_gsm_multicast are registered, 1 cycle after the accepted beat.
  - popped address = FIFO head, read combinationally.
- Header beat while a packet is open (no last seen): treated as implicit last of the old packet, then as a new header.
- Width rules:
  - length is zero-extended to AWIDTH+1 for compare and subtract.
  - the free count never exceeds 2**AWIDTH.
  - a free with a full FIFO is a protocol error; it is ignored and not counted.
- Reset asserted mid-packet: the packet is discarded and the pool is rebuilt by INIT.

Optional Feature:
- Macro: HW_MALLOC_DROP_STATS_EN.
- Defined:
  - adds output o_drop_cnt [15:0], a saturating count of o_pkt_drop pulses.
  - adds output o_overrun_cnt [15:0], a saturating count of o_overrun pulses.
  - both counters clear on rst_n or clr.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Init, AWIDTH=4: release reset → o_ready rises exactly 16 cycles later, o_free_cnt=16. The first 16 allocations give addresses 0..15 in order.
- Reservation: header with length 5, dest=4'b0101, then 4 beats ending with last → 5 write strobes, multicast 0101 on each, o_free_cnt=11 from the cycle after the header.
- Short packet: length 6, last on the 3rd beat → 3 strobes; o_free_cnt goes to 10, then back to 13.
- Drop:
  - full pool of 16 cells; header length 17 → o_pkt_drop pulses, no strobes, count stays 16.
  - header with dest=0 → dropped the same way.
- Overrun: length 2 with 3 beats → 2 strobes, o_overrun pulses once; o_overrun_cnt=1 when the macro is defined.
- Simultaneous events: free_cnt=3, LOW_WM=4; a header of length 3 arrives in the same cycle as a free of address 9 → accepted, free_cnt=1, o_low_space=1. Address 9 is handed out after the 3 addresses already in the FIFO.

Source files
------------

// File: rtl/hw_malloc_rsv_if.sv
// hw_malloc_rsv_if
//   Bus bundle for the reserving cell allocator.
//   Ingress side : i_ingress_pkt_length, i_ingress_dest_ip, i_ingress_valid,
//                  i_ingress_header, i_ingress_last, o_ready
//   GSM side     : o_gsm_multicast, o_gsm_cell_addr, o_gsm_wr_en
//   Free side    : i_free_valid, i_free_addr
//   Status       : o_pkt_drop, o_overrun, o_free_cnt, o_low_space
//   slave modport = allocator, master modport = the block driving ingress/free.
interface hw_malloc_rsv_if #(
    parameter int MWIDTH = 4,
    parameter int LWIDTH = 7,
    parameter int AWIDTH = 7
);
    logic [LWIDTH-1:0] i_ingress_pkt_length;
    logic [31:0]       i_ingress_dest_ip;
    logic              i_ingress_valid;
    logic              i_ingress_header;
    logic              i_ingress_last;
    logic              o_ready;
    logic [MWIDTH-1:0] o_gsm_multicast;
    logic [AWIDTH-1:0] o_gsm_cell_addr;
    logic              o_gsm_wr_en;
    logic              o_pkt_drop;
    logic              o_overrun;
    logic              i_free_valid;
    logic [AWIDTH-1:0] i_free_addr;
    logic [AWIDTH:0]   o_free_cnt;
    logic              o_low_space;

    modport slave (
        input  i_ingress_pkt_length, i_ingress_dest_ip, i_ingress_valid,
               i_ingress_header, i_ingress_last, i_free_valid, i_free_addr,
        output o_ready, o_gsm_multicast, o_gsm_cell_addr, o_gsm_wr_en,
               o_pkt_drop, o_overrun, o_free_cnt, o_low_space
    );

    modport master (
        output i_ingress_pkt_length, i_ingress_dest_ip, i_ingress_valid,
               i_ingress_header, i_ingress_last, i_free_valid, i_free_addr,
        input  o_ready, o_gsm_multicast, o_gsm_cell_addr, o_gsm_wr_en,
               o_pkt_drop, o_overrun, o_free_cnt, o_low_space
    );
endinterface

// File: rtl/hw_malloc_rsv.sv
// hw_malloc_rsv
//   Cell allocator for the GSM switch ingress path. Keeps the free-address
//   pool in an internal FIFO of 2**AWIDTH entries (filled 0..N-1 by an INIT
//   sweep after reset/clr), reserves a packet's whole cell budget on its
//   header, pops one address per accepted beat, and hands unused reservation
//   back at the packet tail. Egress frees push addresses back into the pool.
// Ports:
//   clk, rst_n (async, active low), clr (sync clear, restarts INIT)
//   bus   : hw_malloc_rsv_if.slave (ingress, GSM write, free, status)
// Optional (macro HW_MALLOC_DROP_STATS_EN):
//   o_drop_cnt, o_overrun_cnt : 16-bit saturating pulse counters.
module hw_malloc_rsv #(
    parameter int MWIDTH    = 4,
    parameter int LWIDTH    = 7,
    parameter int AWIDTH    = 7,
    parameter int HM_OFFSET = 0,
    parameter int LOW_WM    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
`ifdef HW_MALLOC_DROP_STATS_EN
    output logic [15:0] o_drop_cnt,
    output logic [15:0] o_overrun_cnt,
`endif
    hw_malloc_rsv_if.slave bus
);
    localparam int DEPTH = 1 << AWIDTH;
    // Arithmetic width wide enough for both the length and the free count,
    // plus headroom so cnt + ret + free cannot wrap before the clamp.
    localparam int CW = ((LWIDTH > AWIDTH + 1) ? LWIDTH : AWIDTH + 1) + 2;

    typedef logic [CW-1:0]   cw_t;
    typedef logic [AWIDTH:0] ptr_t;
    typedef enum logic { ST_INIT, ST_RUN } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] init_addr_q, init_addr_d;
    ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AWIDTH-1:0] mem_q [DEPTH];
    ptr_t              free_cnt_q, free_cnt_d;
    logic [LWIDTH-1:0] rsv_left_q, rsv_left_d;
    logic              pkt_open_q, pkt_open_d;   // accepted packet in flight
    logic              pkt_skip_q, pkt_skip_d;   // rejected packet, ignore to tail
    logic [MWIDTH-1:0] mvec_q, mvec_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic [AWIDTH-1:0] cell_addr_q, cell_addr_d;
    logic [MWIDTH-1:0] gsm_mc_q, gsm_mc_d;
    logic              drop_q, drop_d;
    logic              ovr_q, ovr_d;
    logic              low_q, low_d;

    logic              push, pop;
    logic [AWIDTH-1:0] push_data;
    cw_t               rsv, ret, fre, sum;
    logic [LWIDTH-1:0] left_after;
    logic [MWIDTH-1:0] mvec_in;
    logic              accept, fifo_full;
    cw_t               len_ext;

    assign mvec_in   = bus.i_ingress_dest_ip[HM_OFFSET +: MWIDTH];
    assign len_ext   = cw_t'(bus.i_ingress_pkt_length);
    assign fifo_full = ((wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH));
    // Compare against the registered count; a tail returned in the same
    // cycle by an implicit close is not yet visible to the new header.
    assign accept    = (len_ext != '0) && (len_ext <= cw_t'(free_cnt_q)) && (mvec_in != '0);

    logic unused_dest;
    assign unused_dest = ^bus.i_ingress_dest_ip;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        free_cnt_d  = free_cnt_q;
        rsv_left_d  = rsv_left_q;
        pkt_open_d  = pkt_open_q;
        pkt_skip_d  = pkt_skip_q;
        mvec_d      = mvec_q;
        ready_d     = ready_q;
        cell_addr_d = cell_addr_q;
        gsm_mc_d    = gsm_mc_q;
        low_d       = low_q;
        drop_d      = 1'b0;
        ovr_d       = 1'b0;
        push        = 1'b0;
        push_data   = init_addr_q;
        pop         = 1'b0;
        rsv         = '0;
        ret         = '0;
        fre         = '0;
        sum         = '0;
        left_after  = '0;

        case (state_q)
            ST_INIT: begin
                push        = 1'b1;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == AWIDTH'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    ready_d    = 1'b1;
                    free_cnt_d = ptr_t'(DEPTH);
                end
            end
            default: begin
                if (bus.i_ingress_valid && bus.i_ingress_header) begin
                    // An unterminated packet is closed implicitly first.
                    if (pkt_open_q)
                        ret = cw_t'(rsv_left_q);
                    pkt_open_d = 1'b0;
                    pkt_skip_d = 1'b0;
                    rsv_left_d = '0;
                    if (accept) begin
                        pop      = 1'b1;
                        rsv      = len_ext;
                        mvec_d   = mvec_in;
                        gsm_mc_d = mvec_in;
                        if (bus.i_ingress_last) begin
                            ret = ret + len_ext - cw_t'(1);
                        end else begin
                            pkt_open_d = 1'b1;
                            rsv_left_d = bus.i_ingress_pkt_length - LWIDTH'(1);
                        end
                    end else begin
                        drop_d     = 1'b1;
                        pkt_skip_d = !bus.i_ingress_last;
                    end
                end else if (bus.i_ingress_valid && pkt_open_q) begin
                    if (rsv_left_q != '0) begin
                        pop        = 1'b1;
                        left_after = rsv_left_q - LWIDTH'(1);
                        gsm_mc_d   = mvec_q;
                    end else begin
                        ovr_d = 1'b1;
                    end
                    rsv_left_d = left_after;
                    if (bus.i_ingress_last) begin
                        ret        = cw_t'(left_after);
                        rsv_left_d = '0;
                        pkt_open_d = 1'b0;
                    end
                end else if (bus.i_ingress_valid && pkt_skip_q && bus.i_ingress_last) begin
                    pkt_skip_d = 1'b0;
                end

                if (bus.i_free_valid && !fifo_full) begin
                    push      = 1'b1;
                    push_data = bus.i_free_addr;
                    fre       = cw_t'(1);
                end

                sum = cw_t'(free_cnt_q) + ret + fre - rsv;
                if (sum > cw_t'(DEPTH))
                    sum = cw_t'(DEPTH);
                free_cnt_d = sum[AWIDTH:0];
                low_d      = (sum < cw_t'(LOW_WM));
            end
        endcase

        if (pop)
            cell_addr_d = mem_q[rd_ptr_q[AWIDTH-1:0]];
        wr_en_d  = pop;
        wr_ptr_d = wr_ptr_q + ptr_t'(push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);

        if (clr) begin
            state_d     = ST_INIT;
            init_addr_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            free_cnt_d  = '0;
            rsv_left_d  = '0;
            pkt_open_d  = 1'b0;
            pkt_skip_d  = 1'b0;
            mvec_d      = '0;
            ready_d     = 1'b0;
            wr_en_d     = 1'b0;
            cell_addr_d = '0;
            gsm_mc_d    = '0;
            drop_d      = 1'b0;
            ovr_d       = 1'b0;
            low_d       = 1'b0;
            push        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            free_cnt_q  <= '0;
            rsv_left_q  <= '0;
            pkt_open_q  <= 1'b0;
            pkt_skip_q  <= 1'b0;
            mvec_q      <= '0;
            ready_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cell_addr_q <= '0;
            gsm_mc_q    <= '0;
            drop_q      <= 1'b0;
            ovr_q       <= 1'b0;
            low_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            free_cnt_q  <= free_cnt_d;
            rsv_left_q  <= rsv_left_d;
            pkt_open_q  <= pkt_open_d;
            pkt_skip_q  <= pkt_skip_d;
            mvec_q      <= mvec_d;
            ready_q     <= ready_d;
            wr_en_q     <= wr_en_d;
            cell_addr_q <= cell_addr_d;
            gsm_mc_q    <= gsm_mc_d;
            drop_q      <= drop_d;
            ovr_q       <= ovr_d;
            low_q       <= low_d;
        end
    end

    // Pool storage; contents are meaningless until INIT rewrites them.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AWIDTH-1:0]] <= push_data;
    end

`ifdef HW_MALLOC_DROP_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d, ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        if (drop_d && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (ovr_d && ovr_cnt_q != 16'hFFFF)
            ovr_cnt_d = ovr_cnt_q + 16'd1;
        if (clr) begin
            drop_cnt_d = '0;
            ovr_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign o_drop_cnt    = drop_cnt_q;
    assign o_overrun_cnt = ovr_cnt_q;
`endif

    assign bus.o_ready         = ready_q;
    assign bus.o_gsm_multicast = gsm_mc_q;
    assign bus.o_gsm_cell_addr = cell_addr_q;
    assign bus.o_gsm_wr_en     = wr_en_q;
    assign bus.o_pkt_drop      = drop_q;
    assign bus.o_overrun       = ovr_q;
    assign bus.o_free_cnt      = free_cnt_q;
    assign bus.o_low_space     = low_q;
endmodule

// File: tb/tb_hw_malloc_rsv.sv
// tb_hw_malloc_rsv
//   Self-checking bench for hw_malloc_rsv with a 16-cell pool (AWIDTH=4),
//   LOW_WM=4 and the multicast field at bit 4. Directed scenarios compare
//   against hand-derived constants; the random scenario compares against a
//   queue-based pool model.
module tb_hw_malloc_rsv;
    localparam int MW = 4, LW = 5, AW = 4, HMO = 4, LWM = 4, N = 16;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    always #5 clk = ~clk;

    hw_malloc_rsv_if #(.MWIDTH(MW), .LWIDTH(LW), .AWIDTH(AW)) bus ();

`ifdef HW_MALLOC_DROP_STATS_EN
    logic [15:0] drop_cnt, ovr_cnt;
`endif

    hw_malloc_rsv #(.MWIDTH(MW), .LWIDTH(LW), .AWIDTH(AW), .HM_OFFSET(HMO), .LOW_WM(LWM)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
`ifdef HW_MALLOC_DROP_STATS_EN
        .o_drop_cnt(drop_cnt), .o_overrun_cnt(ovr_cnt),
`endif
        .bus(bus)
    );

    int n_tests = 0, n_fail = 0;
    int init_cycles;

    // Pool model: free addresses in order, allocated addresses, counters.
    int m_q[$];
    int m_alloc[$];
    int m_cnt, m_left, m_mc, m_drops, m_ovrs;
    bit m_open, m_skip;
    bit e_wr, e_drop, e_ovr;
    int e_addr, e_mc;

    task automatic idle_inputs();
        bus.i_ingress_valid = 0; bus.i_ingress_header = 0; bus.i_ingress_last = 0;
        bus.i_ingress_pkt_length = '0; bus.i_ingress_dest_ip = '0;
        bus.i_free_valid = 0; bus.i_free_addr = '0;
    endtask

    // Drives one cycle of stimulus, advances the model, and returns #1
    // after the clock edge where the registered outputs are stable.
    task automatic step(input bit v, input bit h, input bit l, input int len,
                        input int mc, input bit fv, input int fa);
        logic [31:0] d;
        int ret, rsv, cnt0;
        bit pop, full0;
        d = $urandom;
        d[HMO +: MW] = MW'(mc);
        bus.i_ingress_valid = v; bus.i_ingress_header = h; bus.i_ingress_last = l;
        bus.i_ingress_pkt_length = LW'(len); bus.i_ingress_dest_ip = d;
        bus.i_free_valid = fv; bus.i_free_addr = AW'(fa);

        e_wr = 0; e_drop = 0; e_ovr = 0; ret = 0; rsv = 0; pop = 0;
        cnt0 = m_cnt; full0 = (m_q.size() == N);
        if (v && h) begin
            if (m_open) ret += m_left;
            m_open = 0; m_skip = 0; m_left = 0;
            if (len != 0 && len <= cnt0 && mc != 0) begin
                pop = 1; rsv = len; m_mc = mc;
                if (l) ret += len - 1;
                else begin m_open = 1; m_left = len - 1; end
            end else begin
                e_drop = 1; m_skip = !l;
            end
        end else if (v && m_open) begin
            if (m_left > 0) begin pop = 1; m_left--; end
            else e_ovr = 1;
            if (l) begin ret += m_left; m_left = 0; m_open = 0; end
        end else if (v && m_skip && l) begin
            m_skip = 0;
        end
        if (pop) begin
            e_wr = 1; e_addr = m_q.pop_front(); e_mc = m_mc;
            m_alloc.push_back(e_addr);
        end
        if (fv && !full0) begin
            m_q.push_back(fa);
            m_cnt = cnt0 - rsv + ret + 1;
        end else begin
            m_cnt = cnt0 - rsv + ret;
        end
        if (m_cnt > N) m_cnt = N;
        if (e_drop && m_drops < 65535) m_drops++;
        if (e_ovr && m_ovrs < 65535) m_ovrs++;

        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic reset_init();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        init_cycles = 0;
        while (!bus.o_ready && init_cycles < 40) begin
            @(posedge clk); #1;
            init_cycles++;
        end
        n_tests++;
        if (!bus.o_ready) begin
            n_fail++;
            $display("FAIL init_timeout: o_ready still %0b after %0d cycles, need 1", bus.o_ready, init_cycles);
        end
        m_q.delete(); m_alloc.delete();
        for (int i = 0; i < N; i++) m_q.push_back(i);
        m_cnt = N; m_left = 0; m_open = 0; m_skip = 0; m_mc = 0;
        m_drops = 0; m_ovrs = 0; e_addr = 0; e_mc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.o_ready, bus.o_gsm_wr_en, bus.o_gsm_cell_addr, bus.o_gsm_multicast, bus.o_pkt_drop,
             bus.o_overrun, bus.o_free_cnt, bus.o_low_space} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%0b wr=%0b addr=%0d mc=%0h drop=%0b ovr=%0b cnt=%0d low=%0b, all need 0",
                     bus.o_ready, bus.o_gsm_wr_en, bus.o_gsm_cell_addr, bus.o_gsm_multicast,
                     bus.o_pkt_drop, bus.o_overrun, bus.o_free_cnt, bus.o_low_space);
        end
    endtask

    task automatic test_init();
        reset_init();
        n_tests++;
        if (init_cycles != 16 || bus.o_free_cnt !== 5'd16 || bus.o_low_space !== 1'b0) begin
            n_fail++;
            $display("FAIL init_latency: cycles=%0d cnt=%0d low=%0b, need 16/16/0",
                     init_cycles, bus.o_free_cnt, bus.o_low_space);
        end
        // One 16-cell packet drains the pool in address order.
        for (int i = 0; i < N; i++) begin
            step(1, i == 0, i == N - 1, N, 4'b1001, 0, 0);
            n_tests++;
            if (bus.o_gsm_wr_en !== 1'b1 || bus.o_gsm_cell_addr !== AW'(i)) begin
                n_fail++;
                $display("FAIL init_order[%0d]: wr=%0b addr=%0d, need 1/%0d", i, bus.o_gsm_wr_en, bus.o_gsm_cell_addr, i);
            end
        end
        n_tests++;
        if (bus.o_free_cnt !== 5'd0 || bus.o_low_space !== 1'b1) begin
            n_fail++;
            $display("FAIL init_drain: cnt=%0d low=%0b, need 0/1", bus.o_free_cnt, bus.o_low_space);
        end
    endtask

    task automatic test_reservation();
        int strobes = 0;
        reset_init();
        for (int i = 0; i < 5; i++) begin
            step(1, i == 0, i == 4, 5, 4'b0101, 0, 0);
            strobes += bus.o_gsm_wr_en;
            n_tests++;
            if (bus.o_gsm_multicast !== 4'b0101 || bus.o_free_cnt !== 5'd11) begin
                n_fail++;
                $display("FAIL rsv_beat[%0d]: mc=%b cnt=%0d, need 0101/11", i, bus.o_gsm_multicast, bus.o_free_cnt);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (strobes != 5 || bus.o_gsm_wr_en !== 1'b0 || bus.o_free_cnt !== 5'd11) begin
            n_fail++;
            $display("FAIL rsv_total: strobes=%0d wr=%0b cnt=%0d, need 5/0/11", strobes, bus.o_gsm_wr_en, bus.o_free_cnt);
        end
    endtask

    task automatic test_short_packet();
        int strobes = 0;
        reset_init();
        step(1, 1, 0, 6, 4'b0011, 0, 0);
        strobes += bus.o_gsm_wr_en;
        n_tests++;
        if (bus.o_free_cnt !== 5'd10) begin
            n_fail++;
            $display("FAIL short_hdr_cnt: cnt=%0d, need 10", bus.o_free_cnt);
        end
        step(1, 0, 0, 0, 0, 0, 0); strobes += bus.o_gsm_wr_en;
        step(1, 0, 1, 0, 0, 0, 0); strobes += bus.o_gsm_wr_en;
        n_tests++;
        if (strobes != 3 || bus.o_free_cnt !== 5'd13) begin
            n_fail++;
            $display("FAIL short_tail: strobes=%0d cnt=%0d, need 3/13", strobes, bus.o_free_cnt);
        end
    endtask

    task automatic test_drop();
        reset_init();
        step(1, 1, 0, 17, 4'b0001, 0, 0);
        n_tests++;
        if (bus.o_pkt_drop !== 1'b1 || bus.o_gsm_wr_en !== 1'b0 || bus.o_free_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL drop_len: drop=%0b wr=%0b cnt=%0d, need 1/0/16", bus.o_pkt_drop, bus.o_gsm_wr_en, bus.o_free_cnt);
        end
        step(1, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_pkt_drop !== 1'b0 || bus.o_gsm_wr_en !== 1'b0 || bus.o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_tail: drop=%0b wr=%0b ovr=%0b, need 0/0/0", bus.o_pkt_drop, bus.o_gsm_wr_en, bus.o_overrun);
        end
        step(1, 1, 1, 3, 4'b0000, 0, 0);
        n_tests++;
        if (bus.o_pkt_drop !== 1'b1 || bus.o_gsm_wr_en !== 1'b0 || bus.o_free_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL drop_dest0: drop=%0b wr=%0b cnt=%0d, need 1/0/16", bus.o_pkt_drop, bus.o_gsm_wr_en, bus.o_free_cnt);
        end
`ifdef HW_MALLOC_DROP_STATS_EN
        n_tests++;
        if (drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d, need 2", drop_cnt);
        end
`endif
    endtask

    task automatic test_overrun();
        int strobes = 0, ovrs = 0;
        reset_init();
        for (int i = 0; i < 3; i++) begin
            step(1, i == 0, i == 2, 2, 4'b1000, 0, 0);
            strobes += bus.o_gsm_wr_en;
            ovrs += bus.o_overrun;
        end
        step(0, 0, 0, 0, 0, 0, 0);
        ovrs += bus.o_overrun;
        n_tests++;
        if (strobes != 2 || ovrs != 1 || bus.o_free_cnt !== 5'd14) begin
            n_fail++;
            $display("FAIL overrun: strobes=%0d ovr_pulses=%0d cnt=%0d, need 2/1/14", strobes, ovrs, bus.o_free_cnt);
        end
`ifdef HW_MALLOC_DROP_STATS_EN
        n_tests++;
        if (ovr_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL overrun_cnt: got %0d, need 1", ovr_cnt);
        end
`endif
    endtask

    task automatic test_simultaneous();
        reset_init();
        for (int i = 0; i < 13; i++) step(1, i == 0, i == 12, 13, 4'b0110, 0, 0);
        n_tests++;
        if (bus.o_free_cnt !== 5'd3 || bus.o_low_space !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_setup: cnt=%0d low=%0b, need 3/1", bus.o_free_cnt, bus.o_low_space);
        end
        step(1, 1, 0, 3, 4'b0010, 1, 9);
        n_tests++;
        if (bus.o_gsm_cell_addr !== 4'd13 || bus.o_free_cnt !== 5'd1 || bus.o_low_space !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_hdr: addr=%0d cnt=%0d low=%0b, need 13/1/1", bus.o_gsm_cell_addr, bus.o_free_cnt, bus.o_low_space);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (bus.o_gsm_cell_addr !== 4'd15) begin
            n_fail++;
            $display("FAIL simul_tail_addr: addr=%0d, need 15", bus.o_gsm_cell_addr);
        end
        step(1, 1, 1, 1, 4'b0100, 0, 0);
        n_tests++;
        if (bus.o_gsm_wr_en !== 1'b1 || bus.o_gsm_cell_addr !== 4'd9 || bus.o_free_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL simul_freed_addr: wr=%0b addr=%0d cnt=%0d, need 1/9/0", bus.o_gsm_wr_en, bus.o_gsm_cell_addr, bus.o_free_cnt);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        reset_init();
        for (int c = 0; c < 3000; c++) begin
            bit v, h, l, fv;
            int len, mc, fa, k;
            v   = ($urandom_range(0, 3) != 0);
            h   = ($urandom_range(0, 5) == 0);
            l   = ($urandom_range(0, 3) == 0);
            len = $urandom_range(0, 18);
            mc  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            fv  = 0; fa = 0;
            if (m_alloc.size() != 0 && $urandom_range(0, 2) == 0) begin
                k  = $urandom_range(0, m_alloc.size() - 1);
                fa = m_alloc[k];
                m_alloc.delete(k);
                fv = 1;
            end
            step(v, h, l, len, mc, fv, fa);
            n_tests++;
            if (bus.o_gsm_wr_en !== e_wr || bus.o_gsm_cell_addr !== AW'(e_addr) ||
                bus.o_gsm_multicast !== MW'(e_mc) || bus.o_pkt_drop !== e_drop ||
                bus.o_overrun !== e_ovr || bus.o_free_cnt !== 5'(m_cnt) ||
                bus.o_low_space !== (m_cnt < LWM)) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: wr=%0b addr=%0d mc=%0h drop=%0b ovr=%0b cnt=%0d low=%0b, need %0b/%0d/%0h/%0b/%0b/%0d/%0b",
                             c, bus.o_gsm_wr_en, bus.o_gsm_cell_addr, bus.o_gsm_multicast, bus.o_pkt_drop,
                             bus.o_overrun, bus.o_free_cnt, bus.o_low_space,
                             e_wr, e_addr, e_mc, e_drop, e_ovr, m_cnt, (m_cnt < LWM));
            end
        end
`ifdef HW_MALLOC_DROP_STATS_EN
        n_tests++;
        if (drop_cnt !== 16'(m_drops) || ovr_cnt !== 16'(m_ovrs)) begin
            n_fail++;
            $display("FAIL random_stats: drops=%0d ovrs=%0d, need %0d/%0d", drop_cnt, ovr_cnt, m_drops, m_ovrs);
        end
`endif
    endtask

    task automatic test_clear();
        reset_init();
        step(1, 1, 0, 4, 4'b0001, 0, 0);
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        n_tests++;
        if (bus.o_ready !== 1'b0 || bus.o_free_cnt !== 5'd0 || bus.o_gsm_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_state: rdy=%0b cnt=%0d wr=%0b, need 0/0/0", bus.o_ready, bus.o_free_cnt, bus.o_gsm_wr_en);
        end
        init_cycles = 0;
        while (!bus.o_ready && init_cycles < 40) begin
            @(posedge clk); #1;
            init_cycles++;
        end
        n_tests++;
        if (init_cycles != 16 || bus.o_free_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL clr_reinit: cycles=%0d cnt=%0d, need 16/16", init_cycles, bus.o_free_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_init();
        test_reservation();
        test_short_packet();
        test_drop();
        test_overrun();
        test_simultaneous();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
